wavetable_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port wavetable ROM between N voice-slot requesters (16 channels × right/left = 32 by default). Requesters raise a level request with an address. The arbiter grants one per cycle, drives the ROM read port, and returns the ROM word to the granted requester after the ROM read latency. It replaces fixed-priority, one-hot-by-construction sharing, so simultaneous requests are serialized fairly instead of being a protocol error.

---
 rtl/wavetable_if.sv | 29 ++
 rtl/wavetable_arbiter.sv | 100 ++++++++++
 tb/tb_wavetable_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wavetable_if.sv
// Wavetable arbiter bus: requester side, ROM read port and response/status.
interface wavetable_if #(
    parameter int N  = 32,
    parameter int AW = 10,
    parameter int DW = 18
);
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic            hold;
    logic [N-1:0]    ack;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [15:0]     conflict_cnt;

    // Environment side: requesters, hold control and the ROM output word.
    modport master (
        output req, req_addr, hold, rd_data,
        input  ack, rd_en, rd_addr, rsp_valid, rsp_data, conflict_cnt
    );

    // Arbiter side.
    modport slave (
        input  req, req_addr, hold, rd_data,
        output ack, rd_en, rd_addr, rsp_valid, rsp_data, conflict_cnt
    );
endinterface

// File: rtl/wavetable_arbiter.sv
// Round-robin arbiter sharing one single-port wavetable ROM among N requesters.
// One grant per cycle; the ROM word returns to the granted requester RD_LAT+1
// cycles after its ack.
module wavetable_arbiter #(
    parameter int N      = 32,
    parameter int AW     = 10,
    parameter int DW     = 18,
    parameter int RD_LAT = 1
) (
    input logic        clk,
    input logic        rst,
    wavetable_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic          grant;
    logic [PW-1:0] gidx;
    logic [PW-1:0] cand;
    logic [PW-1:0] ptr_next;

    logic [RD_LAT-1:0]         pipe_v;
    logic [RD_LAT-1:0][PW-1:0] pipe_idx;

    // Pick the first requester at or after ptr (circularly); none under rst or hold.
    always_comb begin
        grant = 1'b0;
        gidx  = '0;
        cand  = '0;
        if (!rst && !bus.hold) begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = PW'((32'(ptr) + k) % N);
                if (!grant && bus.req[cand]) begin
                    grant = 1'b1;
                    gidx  = cand;
                end
            end
        end
    end

    // Drive the ROM port and the one-hot ack for the winner.
    always_comb begin
        bus.ack     = '0;
        bus.rd_en   = grant;
        bus.rd_addr = '0;
        if (grant) begin
            bus.ack[gidx] = 1'b1;
            bus.rd_addr   = bus.req_addr[gidx*AW +: AW];
        end
    end

    assign ptr_next = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;

    // Priority pointer moves just past the winner.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (grant)
            ptr <= ptr_next;
    end

    // Valid bits track outstanding ROM reads; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= grant;
            for (int unsigned k = 1; k < RD_LAT; k++)
                pipe_v[k] <= pipe_v[k-1];
        end
    end

    // Requester index rides alongside each outstanding read.
    always_ff @(posedge clk) begin
        pipe_idx[0] <= gidx;
        for (int unsigned k = 1; k < RD_LAT; k++)
            pipe_idx[k] <= pipe_idx[k-1];
    end

    // The last pipeline entry lines up with valid rd_data; register it as the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else if (pipe_v[RD_LAT-1]) begin
            bus.rsp_valid <= N'(1) << pipe_idx[RD_LAT-1];
            bus.rsp_data  <= bus.rd_data;
        end else begin
            bus.rsp_valid <= '0;
        end
    end

    // Saturating count of cycles where two or more requesters contend.
    always_ff @(posedge clk) begin
        if (rst)
            bus.conflict_cnt <= '0;
        else if (!bus.hold && ($countones(bus.req) >= 2) && (bus.conflict_cnt != 16'hFFFF))
            bus.conflict_cnt <= bus.conflict_cnt + 16'd1;
    end
endmodule

// File: tb/tb_wavetable_arbiter.sv
// Self-checking bench for wavetable_arbiter: one RD_LAT=1 and one RD_LAT=3
// instance share the same requests; a cycle-scheduled model checks both.
module tb_wavetable_arbiter;
    logic clk = 1'b0;
    logic rst;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wavetable_if #(.N(32), .AW(10), .DW(18)) if1 ();
    wavetable_if #(.N(32), .AW(10), .DW(18)) if3 ();

    wavetable_arbiter #(.N(32), .AW(10), .DW(18), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );
    wavetable_arbiter #(.N(32), .AW(10), .DW(18), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(if3)
    );

    assign if3.req      = if1.req;
    assign if3.req_addr = if1.req_addr;
    assign if3.hold     = if1.hold;

    // Bench ROM contents: distinct word per address.
    function automatic logic [17:0] rom_f(input logic [9:0] a);
        return {8'hA5, a};
    endfunction

    logic [17:0] rom1, r3a, r3b, r3c;
    always @(posedge clk) begin
        rom1 <= rom_f(if1.rd_addr);
        r3a  <= rom_f(if3.rd_addr);
        r3b  <= r3a;
        r3c  <= r3b;
    end
    assign if1.rd_data = rom1;
    assign if3.rd_data = r3c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] addr_of(input int i);
        return if1.req_addr[i*10 +: 10];
    endfunction

    // Lowest set bit of the request vector rotated so ptr sits at bit 0.
    function automatic void model_grant(input logic [31:0] r, input int p,
                                        output bit f, output int g);
        logic [63:0] d;
        d = {r, r} >> p;
        f = 1'b0;
        g = 0;
        for (int b = 31; b >= 0; b--)
            if (d[b]) begin
                f = 1'b1;
                g = (p + b) % 32;
            end
    endfunction

    int          m_ptr = 0;
    int          m_cnt = 0;
    int          cyc = 0;
    int          s1_idx[int];
    logic [17:0] s1_dat[int];
    int          s3_idx[int];
    logic [17:0] s3_dat[int];
    logic [17:0] cur1 = '0;
    logic [17:0] cur3 = '0;

    // Model: check every mid-cycle, then advance model state for the coming edge.
    always @(negedge clk) begin
        bit          f;
        int          g;
        logic [31:0] e_ack, e_rv1, e_rv3;
        logic [9:0]  e_addr;
        if (mon_en) begin
            f = 1'b0;
            g = 0;
            if (!rst && !if1.hold)
                model_grant(if1.req, m_ptr, f, g);
            e_ack  = f ? (32'd1 << g) : 32'd0;
            e_addr = f ? addr_of(g) : 10'd0;
            check("ack_lat1", if1.ack, e_ack);
            check("ack_lat3", if3.ack, e_ack);
            check("rd_en_lat1", if1.rd_en, f);
            check("rd_en_lat3", if3.rd_en, f);
            check("rd_addr_lat1", if1.rd_addr, e_addr);
            check("rd_addr_lat3", if3.rd_addr, e_addr);

            e_rv1 = '0;
            if (s1_idx.exists(cyc)) begin
                e_rv1 = 32'd1 << s1_idx[cyc];
                cur1  = s1_dat[cyc];
                s1_idx.delete(cyc);
                s1_dat.delete(cyc);
            end
            e_rv3 = '0;
            if (s3_idx.exists(cyc)) begin
                e_rv3 = 32'd1 << s3_idx[cyc];
                cur3  = s3_dat[cyc];
                s3_idx.delete(cyc);
                s3_dat.delete(cyc);
            end
            check("rsp_valid_lat1", if1.rsp_valid, e_rv1);
            check("rsp_data_lat1", if1.rsp_data, cur1);
            check("rsp_valid_lat3", if3.rsp_valid, e_rv3);
            check("rsp_data_lat3", if3.rsp_data, cur3);
            check("conflict_lat1", if1.conflict_cnt, m_cnt);
            check("conflict_lat3", if3.conflict_cnt, m_cnt);

            if (rst) begin
                m_ptr = 0;
                m_cnt = 0;
                cur1  = '0;
                cur3  = '0;
                for (int d = 1; d <= 4; d++) begin
                    if (s1_idx.exists(cyc + d)) begin s1_idx.delete(cyc + d); s1_dat.delete(cyc + d); end
                    if (s3_idx.exists(cyc + d)) begin s3_idx.delete(cyc + d); s3_dat.delete(cyc + d); end
                end
            end else begin
                if (f) begin
                    m_ptr = (g + 1) % 32;
                    s1_idx[cyc + 2] = g;
                    s1_dat[cyc + 2] = rom_f(e_addr);
                    s3_idx[cyc + 4] = g;
                    s3_dat[cyc + 4] = rom_f(e_addr);
                end
                if (!if1.hold && $countones(if1.req) >= 2 && m_cnt != 65535)
                    m_cnt++;
            end
            cyc++;
        end
    end

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [9:0] a);
        if1.req_addr[i*10 +: 10] = a;
    endtask

    initial begin
        rst         = 1'b1;
        if1.req     = '0;
        if1.req_addr = '0;
        if1.hold    = 1'b0;
        pos();
        mon_en = 1'b1;
        neg();
        check("reset_rsp_valid", if1.rsp_valid, 32'd0);
        check("reset_rsp_data", if1.rsp_data, 18'd0);
        check("reset_conflict", if1.conflict_cnt, 16'd0);
        check("reset_rd_en", if1.rd_en, 1'b0);
        pos();
        rst = 1'b0;
        neg(); pos();

        // Single request from requester 5.
        if1.req = 32'h20;
        set_addr(5, 10'h123);
        neg();
        check("single_ack", if1.ack, 32'h20);
        check("single_rd_addr", if1.rd_addr, 10'h123);
        pos();
        if1.req = '0;
        neg(); pos();
        neg();
        check("single_rsp_valid1", if1.rsp_valid, 32'h20);
        check("single_rsp_data1", if1.rsp_data, 18'h29523);
        pos();
        neg(); pos();
        neg();
        check("single_rsp_valid3", if3.rsp_valid, 32'h20);
        check("single_rsp_data3", if3.rsp_data, 18'h29523);
        pos();

        // All 32 requesting from reset.
        rst = 1'b1;
        neg(); pos();
        rst = 1'b0;
        for (int i = 0; i < 32; i++)
            set_addr(i, 10'(i * 3 + 1));
        if1.req = '1;
        for (int k = 0; k < 40; k++) begin
            neg();
            check("rr_ack", if1.ack, 32'd1 << (k % 32));
            if (k >= 2) begin
                check("rr_rsp_valid1", if1.rsp_valid, 32'd1 << ((k - 2) % 32));
                check("rr_rsp_data1", if1.rsp_data, {8'hA5, 10'(((k - 2) % 32) * 3 + 1)});
            end
            if (k >= 4)
                check("rr_rsp_valid3", if3.rsp_valid, 32'd1 << ((k - 4) % 32));
            if (k == 32)
                check("rr_conflict_32", if1.conflict_cnt, 16'd32);
            pos();
        end
        if1.req = '0;

        // Wrap-around: ptr=8 -> grant 29 leaves ptr=30.
        if1.req = 32'd1 << 29;
        neg(); check("wrap_prep_ack", if1.ack, 32'd1 << 29); pos();
        if1.req = (32'd1 << 2) | (32'd1 << 31);
        neg(); check("wrap_ack31", if1.ack, 32'd1 << 31); pos();
        if1.req = 32'd1 << 2;
        neg(); check("wrap_ack2", if1.ack, 32'd1 << 2); pos();
        if1.req = (32'd1 << 2) | (32'd1 << 3);
        neg(); check("wrap_ptr3", if1.ack, 32'd1 << 3); pos();
        if1.req = '0;

        // Hold with two reads in flight; ptr ends at 0 before hold.
        rst = 1'b1;
        neg(); pos();
        rst = 1'b0;
        if1.req = (32'd1 << 30) | (32'd1 << 31);
        neg(); check("hold_pre30", if1.ack, 32'd1 << 30); pos();
        if1.req = 32'd1 << 31;
        neg(); check("hold_pre31", if1.ack, 32'd1 << 31); pos();
        if1.hold = 1'b1;
        if1.req  = 32'd1 | (32'd1 << 7);
        set_addr(0, 10'h055);
        set_addr(7, 10'h3AA);
        for (int h = 0; h < 5; h++) begin
            neg();
            check("hold_no_ack", if1.ack, 32'd0);
            if (h == 0) check("hold_rsp30_lat1", if1.rsp_valid, 32'd1 << 30);
            if (h == 1) check("hold_rsp31_lat1", if1.rsp_valid, 32'd1 << 31);
            if (h == 2) check("hold_rsp30_lat3", if3.rsp_valid, 32'd1 << 30);
            if (h == 3) check("hold_rsp31_lat3", if3.rsp_valid, 32'd1 << 31);
            pos();
        end
        if1.hold = 1'b0;
        neg();
        check("hold_release_ack0", if1.ack, 32'd1);
        check("hold_conflict", if1.conflict_cnt, 16'd1);
        pos();
        if1.req = 32'd1 << 7;
        neg(); check("hold_release_ack7", if1.ack, 32'd1 << 7); pos();
        if1.req = '0;
        neg(); pos();

        // Reset the cycle after an ack: that read must never respond.
        if1.req = 32'd1 << 4;
        set_addr(4, 10'h2C4);
        neg(); check("midrst_ack4", if1.ack, 32'd1 << 4); pos();
        if1.req = '0;
        rst = 1'b1;
        neg(); pos();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            neg();
            check("midrst_rsp_valid1", if1.rsp_valid, 32'd0);
            check("midrst_rsp_valid3", if3.rsp_valid, 32'd0);
            check("midrst_rsp_data1", if1.rsp_data, 18'd0);
            check("midrst_conflict", if1.conflict_cnt, 16'd0);
            pos();
        end

        // Back-to-back grants to one requester with a changing address.
        for (int k = 0; k < 12; k++) begin
            if1.req = (k < 8) ? (32'd1 << 9) : 32'd0;
            set_addr(9, 10'(16'h100 + k * 7));
            neg();
            if (k < 8) check("b2b_ack", if1.ack, 32'd1 << 9);
            if (k >= 2 && k < 10)
                check("b2b_rsp_data1", if1.rsp_data, {8'hA5, 10'(16'h100 + (k - 2) * 7)});
            if (k >= 4) begin
                check("b2b_rsp_valid3", if3.rsp_valid, 32'd1 << 9);
                check("b2b_rsp_data3", if3.rsp_data, {8'hA5, 10'(16'h100 + (k - 4) * 7)});
            end
            pos();
        end

        // Saturation of the conflict counter.
        rst = 1'b1;
        neg(); pos();
        rst = 1'b0;
        if1.req = 32'd3;
        for (int k = 0; k < 70000; k++) begin
            set_addr(0, 10'(k));
            set_addr(1, ~10'(k));
            neg(); pos();
        end
        neg();
        check("sat_conflict_lat1", if1.conflict_cnt, 16'hFFFF);
        check("sat_conflict_lat3", if3.conflict_cnt, 16'hFFFF);
        pos();
        if1.req = '0;
        for (int k = 0; k < 6; k++) begin
            neg(); pos();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
